cmp_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one N-bit subtract-based less-than comparator among NREQ bus requesters.
- Each requester presents an operand pair and holds a request; the block grants one requester at a time, latches its operands, evaluates the compare, and returns a registered result with a one-cycle acknowledge.
- Sits beside the unidirectional bus datapath as the single compare resource for address and priority checks.

---
 rtl/cmp_share_arbiter_if.sv | 24 ++
 rtl/cmp_share_arbiter.sv | 131 +++++++++++++
 tb/tb_cmp_share_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cmp_share_arbiter_if.sv
// Requester-side bus of the shared comparator: per-requester request and
// operand pairs in, one-hot grant/acknowledge and the compare result out.
interface cmp_share_arbiter_if #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned NREQ     = 4
);
  logic [NREQ-1:0]          req;
  logic [NREQ*BITWIDTH-1:0] a_in;
  logic [NREQ*BITWIDTH-1:0] b_in;
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          ack;
  logic                     lt;
  logic                     busy;

  modport master (
    output req, a_in, b_in,
    input  gnt, ack, lt, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, ack, lt, busy
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one subtract-based less-than
// comparator among NREQ requesters: grant, evaluate, acknowledge.
module cmp_share_arbiter_lt #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  output logic                lt
);
  logic [BITWIDTH-1:0] diff;

  // Sign bit of the wrapped difference; overflow is intentionally not corrected.
  assign diff = a - b;
  assign lt   = diff[BITWIDTH-1];
endmodule

module cmp_share_arbiter #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned PTRW     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cmp_share_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                 state;
  logic [PTRW-1:0]        ptr;
  logic [PTRW-1:0]        win;
  logic [PTRW-1:0]        win_next;
  logic                   found;
  logic [(1<<PTRW)-1:0]   req_ext;
  logic [PTRW:0]          idx_sum;
  logic [NREQ-1:0]        win_onehot;
  logic [BITWIDTH-1:0]    a_sel;
  logic [BITWIDTH-1:0]    b_sel;
  logic [BITWIDTH-1:0]    a_q;
  logic [BITWIDTH-1:0]    b_q;
  logic [NREQ-1:0]        gnt_q;
  logic [NREQ-1:0]        ack_q;
  logic                   lt_q;
  logic                   busy_q;
  logic                   cmp_lt;

  // Pad the request vector to a power of two so a PTRW-bit index is always in range.
  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = bus.req;
  end

  always_comb begin
    found    = 1'b0;
    win_next = '0;
    idx_sum  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, ptr} + (PTRW+1)'(k);
      if (idx_sum >= (PTRW+1)'(NREQ)) begin
        idx_sum = idx_sum - (PTRW+1)'(NREQ);
      end
      if (!found && req_ext[idx_sum[PTRW-1:0]]) begin
        found    = 1'b1;
        win_next = idx_sum[PTRW-1:0];
      end
    end
  end

  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_next;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_next == PTRW'(i)) begin
        a_sel = bus.a_in[i*BITWIDTH +: BITWIDTH];
        b_sel = bus.b_in[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  cmp_share_arbiter_lt #(.BITWIDTH(BITWIDTH)) u_cmp (
    .a  (a_q),
    .b  (b_q),
    .lt (cmp_lt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      gnt_q  <= '0;
      ack_q  <= '0;
      lt_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            win    <= win_next;
            gnt_q  <= win_onehot;
            busy_q <= 1'b1;
            state  <= EVAL;
          end
        end
        EVAL: begin
          lt_q  <= cmp_lt;
          ack_q <= gnt_q;
          state <= DONE;
        end
        DONE: begin
          ack_q  <= '0;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          ptr    <= (win == PTRW'(NREQ-1)) ? '0 : win + PTRW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.lt   = lt_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter; expected acks are queued by the
// stimulus and consumed by an independent monitor.
module tb_cmp_share_arbiter;
  localparam int unsigned BW = 8;
  localparam int unsigned NR = 4;

  typedef struct {
    logic [NR-1:0] ack;
    logic          lt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   last_cyc = -1;
  bit   check_spacing = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cmp_share_arbiter_if #(.BITWIDTH(BW), .NREQ(NR)) bus ();

  cmp_share_arbiter #(.BITWIDTH(BW), .NREQ(NR), .PTRW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input logic [NR-1:0] ack, input logic lt);
    exp_t e;
    e.ack = ack;
    e.lt  = lt;
    q.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
    bus.a_in[i*BW +: BW] = a;
    bus.b_in[i*BW +: BW] = b;
  endtask

  task automatic wait_ack_drop(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack[i] !== 1'b1 && n < 30);
    if (bus.ack[i] !== 1'b1) chk("ack_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #2;
    bus.req[i] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'(0));
  endtask

  // Monitor: every acknowledge must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.ack !== '0) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'(bus.ack), 32'(0));
        end else begin
          e = q.pop_front();
          chk("ack", 32'(bus.ack), 32'(e.ack));
          chk("lt", 32'(bus.lt), 32'(e.lt));
          chk("gnt_at_ack", 32'(bus.gnt), 32'(e.ack));
          chk("busy_at_ack", 32'(bus.busy), 32'(1));
        end
        if (check_spacing) begin
          if (last_cyc >= 0) chk("ack_spacing", 32'(cyc - last_cyc), 32'(3));
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_ack", 32'(bus.ack), 32'(0));
    chk("rst_lt", 32'(bus.lt), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));

    // Single request: grant next cycle, ack two cycles after the request.
    @(posedge clk); #2;
    set_op(0, 8'd3, 8'd5);
    push(4'b0001, 1'b1);
    bus.req = 4'b0001;
    @(posedge clk); @(negedge clk);
    chk("t1_gnt", 32'(bus.gnt), 32'(4'b0001));
    chk("t1_busy_eval", 32'(bus.busy), 32'(1));
    chk("t1_ack_eval", 32'(bus.ack), 32'(0));
    @(posedge clk); @(negedge clk);
    chk("t1_busy_done", 32'(bus.busy), 32'(1));
    @(posedge clk); #2;
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t1_busy_idle", 32'(bus.busy), 32'(0));
    chk("t1_gnt_idle", 32'(bus.gnt), 32'(0));

    // Wrap-around compares on requester 1.
    @(posedge clk); #2;
    set_op(1, 8'h80, 8'h01); push(4'b0010, 1'b0); bus.req[1] = 1'b1;
    wait_ack_drop(1);
    set_op(1, 8'h01, 8'h80); push(4'b0010, 1'b1); bus.req[1] = 1'b1;
    wait_ack_drop(1);
    set_op(1, 8'h55, 8'h55); push(4'b0010, 1'b0); bus.req[1] = 1'b1;
    wait_ack_drop(1);

    // Pointer is 2 here: 0 wins over 1 by wrapping, then 1 is served.
    set_op(0, 8'h10, 8'h20);
    set_op(1, 8'h20, 8'h10);
    push(4'b0001, 1'b1);
    push(4'b0010, 1'b0);
    bus.req = 4'b0011;
    wait_ack_drop(0);
    wait_ack_drop(1);

    // Operands changed and req dropped after the grant edge.
    set_op(2, 8'd10, 8'd20);
    push(4'b0100, 1'b1);
    bus.req[2] = 1'b1;
    @(posedge clk); #2;
    chk("mid_gnt", 32'(bus.gnt), 32'(4'b0100));
    set_op(2, 8'd30, 8'd5);
    bus.req[2] = 1'b0;
    wait_drain(20);

    // Reset while in EVAL drops the transaction.
    @(posedge clk); #2;
    set_op(0, 8'd1, 8'd2);
    bus.req = 4'b0001;
    @(posedge clk); #2;
    chk("rst_eval_gnt", 32'(bus.gnt), 32'(4'b0001));
    reset = 1'b1;
    bus.req = 4'b0000;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_gnt", 32'(bus.gnt), 32'(0));
    chk("rst2_ack", 32'(bus.ack), 32'(0));
    chk("rst2_lt", 32'(bus.lt), 32'(0));
    chk("rst2_busy", 32'(bus.busy), 32'(0));
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    set_op(3, 8'h10, 8'h20);
    push(4'b1000, 1'b1);
    bus.req = 4'b1000;
    wait_ack_drop(3);

    // Fairness under full load; pointer restarts at 0 after requester 3.
    set_op(0, 8'd1, 8'd2);
    set_op(1, 8'd2, 8'd1);
    set_op(2, 8'h7F, 8'hFF);
    set_op(3, 8'd0, 8'd0);
    push(4'b0001, 1'b1);
    push(4'b0010, 1'b0);
    push(4'b0100, 1'b1);
    push(4'b1000, 1'b0);
    push(4'b0001, 1'b1);
    last_cyc = -1;
    check_spacing = 1'b1;
    bus.req = 4'b1111;
    wait_drain(100);
    @(posedge clk); #2;
    bus.req = 4'b0000;
    check_spacing = 1'b0;

    repeat (6) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'(0));
    chk("final_busy", 32'(bus.busy), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
